// File: rtl/rps_pkg.sv
// Shared constants, state type and punch sanitizer for the rock-paper-scissors referee.
package rps_pkg;

  localparam logic [3:0] PUNCH_NONE     = 4'b0000;
  localparam logic [3:0] PUNCH_SCISSORS = 4'b0001;
  localparam logic [3:0] PUNCH_STONE    = 4'b0010;
  localparam logic [3:0] PUNCH_PAPER    = 4'b0100;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_JUDGE,
    ST_SHOW,
    ST_OVER
  } rps_state_t;

  // Anything that is not exactly one of the three legal codes counts as no punch.
  function automatic logic [3:0] rps_sanitize(input logic [3:0] p);
    if (p == PUNCH_SCISSORS || p == PUNCH_STONE || p == PUNCH_PAPER)
      return p;
    return PUNCH_NONE;
  endfunction

endpackage

// File: rtl/rps_referee_if.sv
// Player-side and display-side signals of the referee, bundled as one interface.
interface rps_referee_if;
  logic       tick;
  logic       start;
  logic [3:0] punch_1;
  logic [3:0] punch_2;
  logic [3:0] punch_1_q;
  logic [3:0] punch_2_q;
  logic [1:0] countdown;
  logic [1:0] winner;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       show;
  logic       match_over;
  logic [1:0] champion;

  // Driver side: divider tick, start button and live switches.
  modport master (
    output tick, start, punch_1, punch_2,
    input  punch_1_q, punch_2_q, countdown, winner, score_1, score_2,
           show, match_over, champion
  );

  // Referee side.
  modport slave (
    input  tick, start, punch_1, punch_2,
    output punch_1_q, punch_2_q, countdown, winner, score_1, score_2,
           show, match_over, champion
  );
endinterface

// File: rtl/rps_judge.sv
// Combinational round judge on two sanitized punches; also usable by display logic.
module rps_judge
  import rps_pkg::*;
(
  input  logic [3:0] punch_a_i,
  input  logic [3:0] punch_b_i,
  output logic [1:0] winner_o
);

  // Equal punches (including both empty) draw; an empty side loses to a valid one.
  always_comb begin
    winner_o = WIN_P2;
    if (punch_a_i == punch_b_i)
      winner_o = WIN_DRAW;
    else if (punch_a_i == PUNCH_NONE)
      winner_o = WIN_P2;
    else if (punch_b_i == PUNCH_NONE)
      winner_o = WIN_P1;
    else if ((punch_a_i == PUNCH_STONE    && punch_b_i == PUNCH_SCISSORS) ||
             (punch_a_i == PUNCH_SCISSORS && punch_b_i == PUNCH_PAPER)    ||
             (punch_a_i == PUNCH_PAPER    && punch_b_i == PUNCH_STONE))
      winner_o = WIN_P1;
  end

endmodule

// File: rtl/rps_referee.sv
// Round controller: countdown, punch capture, judging, result display and match scoring.
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  COUNT | counting down 3,2,1 in steps of TICKS_PER_STEP ticks
//  JUDGE | one cycle: register round winner and bump score
//  SHOW  | holding the result for SHOW_TICKS ticks
//  OVER  | a player reached WIN_SCORE; waiting for start
module rps_referee
  import rps_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 2,
  parameter int unsigned SHOW_TICKS     = 4,
  parameter int unsigned WIN_SCORE      = 3
) (
  input  logic         CLK,
  input  logic         Clear,
  rps_referee_if.slave bus
);

  localparam logic [15:0] STEP_LAST = 16'(TICKS_PER_STEP - 1);
  localparam logic [15:0] SHOW_LAST = 16'(SHOW_TICKS - 1);
  localparam logic [3:0]  WIN_PTS   = 4'(WIN_SCORE);

  rps_state_t  state_q;
  logic [15:0] step_q;
  logic [15:0] show_cnt_q;
  logic [1:0]  countdown_q;
  logic [3:0]  punch_1_q;
  logic [3:0]  punch_2_q;
  logic [1:0]  winner_q;
  logic [3:0]  score_1_q;
  logic [3:0]  score_2_q;
  logic        show_q;
  logic        match_over_q;
  logic [1:0]  champion_q;
  logic [1:0]  round_win_d;

  // Judge works on the latched punches, which are stable by the JUDGE cycle.
  rps_judge u_judge (
    .punch_a_i (punch_1_q),
    .punch_b_i (punch_2_q),
    .winner_o  (round_win_d)
  );

  // Main FSM with all outputs registered.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      show_cnt_q   <= '0;
      countdown_q  <= '0;
      punch_1_q    <= PUNCH_NONE;
      punch_2_q    <= PUNCH_NONE;
      winner_q     <= WIN_NONE;
      score_1_q    <= '0;
      score_2_q    <= '0;
      show_q       <= 1'b0;
      match_over_q <= 1'b0;
      champion_q   <= WIN_NONE;
    end else begin
      case (state_q)
        // start takes precedence over a coincident tick, which is dropped.
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            state_q      <= ST_COUNT;
            score_1_q    <= '0;
            score_2_q    <= '0;
            winner_q     <= WIN_NONE;
            champion_q   <= WIN_NONE;
            match_over_q <= 1'b0;
            countdown_q  <= 2'd3;
            step_q       <= '0;
          end
        end

        ST_COUNT: begin
          if (bus.tick) begin
            if (step_q == STEP_LAST) begin
              step_q <= '0;
              countdown_q <= countdown_q - 2'd1;
              if (countdown_q == 2'd1) begin
                punch_1_q <= rps_sanitize(bus.punch_1);
                punch_2_q <= rps_sanitize(bus.punch_2);
                state_q   <= ST_JUDGE;
              end
            end else begin
              step_q <= step_q + 16'd1;
            end
          end
        end

        // Ticks here are deliberately ignored; SHOW counting starts afterwards.
        ST_JUDGE: begin
          winner_q   <= round_win_d;
          show_q     <= 1'b1;
          show_cnt_q <= '0;
          state_q    <= ST_SHOW;
          if (round_win_d == WIN_P1)
            score_1_q <= score_1_q + 4'd1;
          else if (round_win_d == WIN_P2)
            score_2_q <= score_2_q + 4'd1;
        end

        ST_SHOW: begin
          if (bus.tick) begin
            if (show_cnt_q == SHOW_LAST) begin
              show_cnt_q <= '0;
              show_q     <= 1'b0;
              if (score_1_q == WIN_PTS || score_2_q == WIN_PTS) begin
                state_q      <= ST_OVER;
                match_over_q <= 1'b1;
                champion_q   <= (score_1_q == WIN_PTS) ? WIN_P1 : WIN_P2;
              end else begin
                state_q     <= ST_COUNT;
                winner_q    <= WIN_NONE;
                punch_1_q   <= PUNCH_NONE;
                punch_2_q   <= PUNCH_NONE;
                countdown_q <= 2'd3;
                step_q      <= '0;
              end
            end else begin
              show_cnt_q <= show_cnt_q + 16'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.punch_1_q  = punch_1_q;
  assign bus.punch_2_q  = punch_2_q;
  assign bus.countdown  = countdown_q;
  assign bus.winner     = winner_q;
  assign bus.score_1    = score_1_q;
  assign bus.score_2    = score_2_q;
  assign bus.show       = show_q;
  assign bus.match_over = match_over_q;
  assign bus.champion   = champion_q;

endmodule

// File: tb/tb_rps_referee.sv
// Randomized self-checking bench for rps_referee against a round-level game model.
module tb_rps_referee;

  logic CLK;
  logic Clear;
  int   checks;
  int   errors;
  int   exp_s1;
  int   exp_s2;
  bit   exp_over;

  rps_referee_if bus ();

  rps_referee #(
    .TICKS_PER_STEP (2),
    .SHOW_TICKS     (3),
    .WIN_SCORE      (3)
  ) dut (
    .CLK   (CLK),
    .Clear (Clear),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Game model: legal codes are scissors=1, stone=2, paper=4; anything else is no punch.
  function automatic logic [3:0] m_san(input logic [3:0] p);
    return (p == 4'd1 || p == 4'd2 || p == 4'd4) ? p : 4'd0;
  endfunction

  function automatic int m_idx(input logic [3:0] p);
    return (p == 4'd1) ? 0 : (p == 4'd2) ? 1 : 2;
  endfunction

  // Cyclic order scissors < stone < paper < scissors: a beats b when one step ahead.
  function automatic logic [1:0] m_win(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] sa, sb;
    sa = m_san(a);
    sb = m_san(b);
    if (sa == sb) return 2'd3;
    if (sa == 4'd0) return 2'd2;
    if (sb == 4'd0) return 2'd1;
    return (((m_idx(sa) - m_idx(sb) + 3) % 3) == 1) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] rnd_punch();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 4'd1;
    if (r == 1) return 4'd2;
    if (r == 2) return 4'd4;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic step(input bit t);
    bus.tick = t;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_pulse();
    step(0); step(0); step(0); step(1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_p1q"}, 16'(bus.punch_1_q), 16'd0);
    chk({tag, "_p2q"}, 16'(bus.punch_2_q), 16'd0);
    chk({tag, "_cd"}, 16'(bus.countdown), 16'd0);
    chk({tag, "_win"}, 16'(bus.winner), 16'd0);
    chk({tag, "_s1"}, 16'(bus.score_1), 16'd0);
    chk({tag, "_s2"}, 16'(bus.score_2), 16'd0);
    chk({tag, "_show"}, 16'(bus.show), 16'd0);
    chk({tag, "_over"}, 16'(bus.match_over), 16'd0);
    chk({tag, "_champ"}, 16'(bus.champion), 16'd0);
  endtask

  task automatic do_start(input bit with_tick);
    bus.start = 1'b1;
    step(with_tick);
    bus.start = 1'b0;
    exp_s1 = 0;
    exp_s2 = 0;
    exp_over = 0;
    chk("start_cd", 16'(bus.countdown), 16'd3);
    chk("start_s1", 16'(bus.score_1), 16'd0);
    chk("start_s2", 16'(bus.score_2), 16'd0);
    chk("start_over", 16'(bus.match_over), 16'd0);
    chk("start_champ", 16'(bus.champion), 16'd0);
    chk("start_win", 16'(bus.winner), 16'd0);
  endtask

  // One full round; abort pulls Clear low partway through the result display.
  task automatic play_round(input logic [3:0] a, input logic [3:0] b, input bit abort);
    logic [1:0] w;
    for (int k = 1; k <= 5; k++) begin
      bus.punch_1 = 4'($urandom_range(0, 15));
      bus.punch_2 = 4'($urandom_range(0, 15));
      tick_pulse();
      chk("countdown", 16'(bus.countdown), 16'(3 - k / 2));
    end
    step(0); step(0); step(0);
    bus.punch_1 = a;
    bus.punch_2 = b;
    step(1);
    chk("cap_cd", 16'(bus.countdown), 16'd0);
    chk("cap_p1q", 16'(bus.punch_1_q), 16'(m_san(a)));
    chk("cap_p2q", 16'(bus.punch_2_q), 16'(m_san(b)));
    bus.punch_1 = 4'($urandom_range(0, 15));
    bus.punch_2 = 4'($urandom_range(0, 15));
    w = m_win(a, b);
    if (w == 2'd1) exp_s1++;
    if (w == 2'd2) exp_s2++;
    step(1'($urandom_range(0, 1)));
    chk("judge_win", 16'(bus.winner), 16'(w));
    chk("judge_s1", 16'(bus.score_1), 16'(exp_s1));
    chk("judge_s2", 16'(bus.score_2), 16'(exp_s2));
    chk("judge_show", 16'(bus.show), 16'd1);
    if (abort) begin
      tick_pulse();
      Clear = 1'b0;
      #1;
      exp_s1 = 0;
      exp_s2 = 0;
      check_all_zero("clear");
      return;
    end
    for (int k = 1; k <= 3; k++) begin
      tick_pulse();
      if (k < 3) begin
        chk("show_hold", 16'(bus.show), 16'd1);
        chk("show_win", 16'(bus.winner), 16'(w));
      end
    end
    chk("end_show", 16'(bus.show), 16'd0);
    if (exp_s1 == 3 || exp_s2 == 3) begin
      exp_over = 1;
      chk("over", 16'(bus.match_over), 16'd1);
      chk("champ", 16'(bus.champion), (exp_s1 == 3) ? 16'd1 : 16'd2);
      chk("over_win", 16'(bus.winner), 16'(w));
    end else begin
      chk("next_cd", 16'(bus.countdown), 16'd3);
      chk("next_win", 16'(bus.winner), 16'd0);
      chk("next_p1q", 16'(bus.punch_1_q), 16'd0);
      chk("next_p2q", 16'(bus.punch_2_q), 16'd0);
    end
  endtask

  task automatic random_match();
    int n;
    n = 0;
    while (!exp_over && n < 60) begin
      play_round(rnd_punch(), rnd_punch(), 1'b0);
      n++;
    end
    chk("match_ended", 16'(exp_over), 16'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_s1 = 0;
    exp_s2 = 0;
    exp_over = 0;
    Clear = 1'b0;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.punch_1 = 4'd0;
    bus.punch_2 = 4'd0;
    step(0); step(0);
    check_all_zero("reset");
    Clear = 1'b1;
    step(0);

    // Idle ignores ticks until start; start with a coincident tick.
    tick_pulse();
    chk("idle_cd", 16'(bus.countdown), 16'd0);
    do_start(1'b1);
    play_round(4'd1, 4'd1, 1'b0);
    play_round(4'd2, 4'd1, 1'b0);
    play_round(4'd3, 4'd4, 1'b0);
    play_round(4'd0, 4'd8, 1'b0);
    random_match();

    // OVER holds everything until start.
    tick_pulse();
    chk("over_hold", 16'(bus.match_over), 16'd1);
    chk("over_s1", 16'(bus.score_1), 16'(exp_s1));
    chk("over_s2", 16'(bus.score_2), 16'(exp_s2));

    // Player 2 wins three straight with paper over stone.
    do_start(1'b0);
    for (int r = 0; r < 3; r++) play_round(4'd2, 4'd4, 1'b0);
    chk("p2_champ", 16'(bus.champion), 16'd2);
    chk("p2_score", 16'(bus.score_2), 16'd3);

    // Asynchronous clear during the second round's display.
    do_start(1'b1);
    play_round(4'd4, 4'd2, 1'b0);
    play_round(4'd1, 4'd4, 1'b1);
    step(0); step(0);
    Clear = 1'b1;
    tick_pulse(); tick_pulse(); tick_pulse();
    check_all_zero("post_clear");

    // Fully random matches.
    for (int m = 0; m < 3; m++) begin
      do_start(1'($urandom_range(0, 1)));
      random_match();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
